// File: rtl/local_buffer_reader_pkg.sv
// Shared definitions for the PE local-buffer read engine.
// Holds the buffer geometry, which the buffer itself and its write-side master
// also use, and the read FSM state encoding.
package local_buffer_reader_pkg;

  localparam int LB_ADDR_W = 10;
  localparam int LB_DATA_W = 16;
  localparam int LB_DEPTH  = 1 << LB_ADDR_W;

  typedef enum logic [1:0] {
    LBR_IDLE  = 2'd0,
    LBR_READ  = 2'd1,
    LBR_DRAIN = 2'd2
  } lbr_state_e;

endpackage

// File: rtl/lb_rd_fifo2.sv
// Two-entry FIFO that queues words returned by the local buffer until the
// stream consumer accepts them.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push_i      write wdata_i into the tail (never asserted while full)
//   pop_i       drop the head entry (never asserted while empty)
//   wdata_i     entry to write
//   rdata_o     head entry
//   empty_o     no entries held
//   full_o      both entries held
//   count_o     number of entries held (0..2)
module lb_rd_fifo2 #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the stream data output reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;

endmodule

// File: rtl/local_buffer_reader.sv
// Streaming read engine for the PE local buffer. A start command issues a run
// of strided reads on the buffer port, absorbs the one-cycle read latency and
// delivers the words on a valid/ready stream, tagging the final word.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, base_addr, length,   command; operands captured only when idle
//   stride
//   busy, done                  command in progress / one-cycle completion pulse
//   buf_ce, buf_we, buf_addr,   buffer port (read-only master, we tied low)
//   buf_rdata
//   m_valid, m_data, m_last,    output stream
//   m_ready
module local_buffer_reader
  import local_buffer_reader_pkg::*;
#(
  parameter int ADDR_W = LB_ADDR_W,
  parameter int DATA_W = LB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [ADDR_W-1:0] stride,
  output logic              busy,
  output logic              done,
  output logic              buf_ce,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);

  lbr_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [ADDR_W:0]   rem_d;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              zero_done_q;

  logic              fifo_empty;
  logic              fifo_full_unused;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              pop;
  logic              head_last;
  logic [2:0]        outstanding;
  logic              credit;
  logic              issue;
  logic              final_issue;

  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign head_last = fifo_head[DATA_W];

  // Every issued read must have a FIFO slot waiting for it when it lands; a
  // pop in this cycle frees a slot in time for a read issued now.
  assign outstanding = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit      = (outstanding < 3'd2);
  assign issue       = (state_q == LBR_READ) && credit;
  assign final_issue = issue && (rem_q == REM_ONE);

  // Address wraps modulo the buffer depth through natural overflow.
  assign addr_d = addr_q + stride_q;
  assign rem_d  = rem_q - REM_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LBR_IDLE;
      addr_q          <= '0;
      stride_q        <= '0;
      last_addr_q     <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= final_issue;
      zero_done_q     <= 1'b0;
      if (issue) begin
        last_addr_q <= addr_q;
        addr_q      <= addr_d;
        rem_q       <= rem_d;
      end
      case (state_q)
        LBR_IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr_q   <= base_addr;
              stride_q <= stride;
              rem_q    <= length;
              state_q  <= LBR_READ;
            end else begin
              zero_done_q <= 1'b1;
            end
          end
        end
        LBR_READ: begin
          if (final_issue) state_q <= LBR_DRAIN;
        end
        LBR_DRAIN: begin
          if (pop && head_last) state_q <= LBR_IDLE;
        end
        default: state_q <= LBR_IDLE;
      endcase
    end
  end

  // Read data lands the cycle after its issue; tag it with the final flag.
  lb_rd_fifo2 #(
    .WIDTH(DATA_W + 1)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (inflight_q),
    .pop_i  (pop),
    .wdata_i({inflight_last_q, buf_rdata}),
    .rdata_o(fifo_head),
    .empty_o(fifo_empty),
    .full_o (fifo_full_unused),
    .count_o(fifo_count)
  );

  assign m_data   = fifo_head[DATA_W-1:0];
  assign m_last   = head_last;
  assign busy     = (state_q != LBR_IDLE);
  assign done     = zero_done_q || ((state_q == LBR_DRAIN) && pop && head_last);
  assign buf_ce   = issue;
  assign buf_we   = 1'b0;
  assign buf_addr = issue ? addr_q : last_addr_q;

endmodule

// File: tb/tb_local_buffer_reader.sv
module tb_local_buffer_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic [9:0]  stride;
  logic        busy;
  logic        done;
  logic        buf_ce;
  logic        buf_we;
  logic [9:0]  buf_addr;
  logic [15:0] buf_rdata;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_ready;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int rmode  = 0;

  logic [16:0] exp_q[$];
  logic [9:0]  exp_addr_q[$];
  logic [15:0] mem [0:1023];

  local_buffer_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .stride   (stride),
    .busy     (busy),
    .done     (done),
    .buf_ce   (buf_ce),
    .buf_we   (buf_we),
    .buf_addr (buf_addr),
    .buf_rdata(buf_rdata),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Buffer model: registered read, one cycle latency.
  always @(posedge clk) begin
    if (buf_ce && !buf_we) buf_rdata <= mem[buf_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input int b, input int len, input int s);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (b + i * s) % 1024;
      exp_addr_q.push_back(10'(a));
      exp_q.push_back({(i == len - 1), 16'(a + 16'h100)});
    end
  endtask

  task automatic launch(input int b, input int len, input int s);
    tick();
    start = 1'b1;
    base_addr = 10'(b);
    length = 11'(len);
    stride = 10'(s);
    push_cmd(b, len, s);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ce"}, 32'(buf_ce), 0);
    chk({tag, "_we"}, 32'(buf_we), 0);
    chk({tag, "_addr"}, 32'(buf_addr), 0);
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_data"}, 32'(m_data), 0);
    chk({tag, "_last"}, 32'(m_last), 0);
  endtask

  // Downstream ready: always 1, or a 1,0,0 repeating pattern.
  initial begin
    int cyc;
    cyc = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
      cyc++;
    end
  end

  // Scoreboard monitor: address order on the buffer port, word order and
  // last tags on the stream, and stability of a stalled word.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    logic [16:0] e;
    logic [9:0]  ea;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (buf_ce) begin
          chk("buf_we_low", 32'(buf_we), 0);
          if (exp_addr_q.size() == 0) begin
            chk("unexpected_read", 32'(buf_addr), 32'hFFFF_FFFF);
          end else begin
            ea = exp_addr_q.pop_front();
            chk("read_addr", 32'(buf_addr), 32'(ea));
          end
        end
        if (prev_stall) begin
          chk("stall_valid", 32'(m_valid), 1);
          chk("stall_data", 32'({m_last, m_data}), 32'({prev_last, prev_data}));
        end
        if (m_valid && m_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'({m_last, m_data}), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("word", 32'({m_last, m_data}), 32'(e));
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 16'(k + 16'h100);
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    stride = '0;
    #1;
    chk_reset_outputs("por");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Cycle-exact first command: base 5, length 4, stride 1.
    tick();
    start = 1'b1;
    base_addr = 10'd5;
    length = 11'd4;
    stride = 10'd1;
    push_cmd(5, 4, 1);
    @(negedge clk);
    chk("c0_busy", 32'(busy), 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("c1_ce", 32'(buf_ce), 1);
    chk("c1_addr", 32'(buf_addr), 5);
    chk("c1_busy", 32'(busy), 1);
    @(negedge clk);
    chk("c2_valid", 32'(m_valid), 0);
    @(negedge clk);
    chk("c3_valid", 32'(m_valid), 1);
    chk("c3_data", 32'(m_data), 32'h105);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("c6_data", 32'(m_data), 32'h108);
    chk("c6_last", 32'(m_last), 1);
    chk("c6_done", 32'(done), 1);
    @(negedge clk);
    chk("c7_busy", 32'(busy), 0);
    chk("c7_done", 32'(done), 0);
    chk("c7_valid", 32'(m_valid), 0);
    chk("c7_ce", 32'(buf_ce), 0);
    chk("c7_addr_hold", 32'(buf_addr), 8);

    // Address wrap-around.
    launch(1022, 4, 1);
    wait_done("wrap_done", 30);

    // Strided reads with back-pressure.
    rmode = 1;
    launch(0, 8, 3);
    wait_done("stride_done", 200);
    rmode = 0;

    // Zero-length command: done one cycle later, no access, never busy.
    tick();
    start = 1'b1;
    length = 11'd0;
    base_addr = 10'd9;
    stride = 10'd1;
    @(negedge clk);
    chk("z0_done", 32'(done), 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("z1_done", 32'(done), 1);
    chk("z1_busy", 32'(busy), 0);
    chk("z1_ce", 32'(buf_ce), 0);
    @(negedge clk);
    chk("z2_done", 32'(done), 0);
    chk("z2_busy", 32'(busy), 0);

    // Full-depth command rereading a single address.
    launch(7, 1024, 0);
    wait_done("full_done", 1100);

    // Start while busy is ignored.
    launch(100, 6, 1);
    tick();
    start = 1'b1;
    base_addr = 10'd300;
    length = 11'd5;
    stride = 10'd7;
    tick();
    start = 1'b0;
    wait_done("busy_start_done", 50);
    repeat (6) @(negedge clk);
    chk("busy_start_idle", 32'(busy), 0);

    // Reset mid-command after three words delivered.
    hs_cnt = 0;
    launch(50, 10, 2);
    begin
      int n;
      n = 0;
      while (hs_cnt < 3 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("rst_three_words", 32'(hs_cnt), 3);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    exp_q.delete();
    exp_addr_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    launch(200, 3, 5);
    wait_done("post_rst_done", 30);

    repeat (4) @(negedge clk);
    chk("exp_words_left", 32'(exp_q.size()), 0);
    chk("exp_addrs_left", 32'(exp_addr_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
